// File: rtl/lii_stream_adapter.sv
// LII phy <-> HLS kernel stream adapter.
// Input side: one phy beat is split into NIN lanes, each buffered in its own
// FIFO so the kernel can drain lanes at independent rates. Beats addressed to
// another node are consumed and counted, never buffered.
// Output side: NOUT kernel lanes are captured together into a single
// registered phy beat. The kernel clock enable drops only while that beat is
// blocked downstream.
module lii_stream_adapter #(
    parameter int unsigned NIN    = 3,
    parameter int unsigned NOUT   = 1,
    parameter int unsigned IW     = 64,
    parameter int unsigned OW     = 8,
    parameter int unsigned PW     = 256,
    parameter int unsigned DEPTH  = 4,
    parameter logic [7:0]  MY_ID  = 8'h01,
    parameter logic [7:0]  DST_ID = 8'h02
) (
    input  logic                 aclk,
    input  logic                 arstn,

    input  logic [PW-1:0]        lii_in_tdata,
    input  logic                 lii_in_tvalid,
    output logic                 lii_in_tready,
    input  logic [7:0]           lii_in_src,
    input  logic [7:0]           lii_in_dst,

    output logic [PW-1:0]        lii_out_tdata,
    output logic                 lii_out_tvalid,
    input  logic                 lii_out_tready,
    output logic [7:0]           lii_out_src,
    output logic [7:0]           lii_out_dst,

    output logic [NIN*IW-1:0]    k_in_tdata,
    output logic [NIN-1:0]       k_in_tvalid,
    input  logic [NIN-1:0]       k_in_tready,

    input  logic [NOUT*OW-1:0]   k_out_tdata,
    input  logic [NOUT-1:0]      k_out_tvalid,
    output logic [NOUT-1:0]      k_out_tready,

    output logic                 ce,
    output logic [15:0]          drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Input FIFOs: lanes are written in lockstep, so one write pointer serves all.
    logic [IW-1:0]  mem_q    [NIN][DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q [NIN];
    logic [CW-1:0]  cnt_q    [NIN];

    logic [NIN-1:0] not_full;
    logic [NIN-1:0] pop;
    logic           accept;
    logic           push;
    logic           drop;

    logic [15:0]    drop_cnt_q, drop_cnt_d;

    logic [PW-1:0]  out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           all_v;
    logic           slot_free;
    logic           capture;

    // The source tag of incoming beats carries no meaning for this node.
    logic           unused_src;
    assign unused_src = ^lii_in_src;

    // Input ready depends only on FIFO occupancy, never on tvalid.
    always_comb begin
        not_full = '0;
        for (int i = 0; i < int'(NIN); i++) begin
            not_full[i] = cnt_q[i] < FULL;
        end
    end

    assign lii_in_tready = &not_full;
    assign accept        = lii_in_tvalid & lii_in_tready;
    assign push          = accept & (lii_in_dst == MY_ID);
    assign drop          = accept & (lii_in_dst != MY_ID);

    for (genvar g = 0; g < int'(NIN); g++) begin : g_lane
        assign k_in_tvalid[g]            = cnt_q[g] != '0;
        assign k_in_tdata[g*IW +: IW]    = mem_q[g][rd_ptr_q[g]];
        assign pop[g]                    = k_in_tvalid[g] & k_in_tready[g];
    end

    // FIFO storage: data only, no reset needed since count gates visibility.
    always_ff @(posedge aclk) begin
        if (push) begin
            for (int i = 0; i < int'(NIN); i++) begin
                mem_q[i][wr_ptr_q] <= lii_in_tdata[i*IW +: IW];
            end
        end
    end

    // FIFO pointers and occupancy; push and pop on the same lane cancel out.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < int'(NIN); i++) begin
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            for (int i = 0; i < int'(NIN); i++) begin
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                end
                if (push && !pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end else if (!push && pop[i]) begin
                    cnt_q[i] <= cnt_q[i] - CW'(1);
                end
            end
        end
    end

    // Output capture takes all kernel lanes at once, or none of them.
    assign all_v        = &k_out_tvalid;
    assign slot_free    = !out_valid_q | lii_out_tready;
    assign capture      = all_v & slot_free;
    assign k_out_tready = {NOUT{capture}};

    // Next state for the output register and the saturating drop counter.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        drop_cnt_d  = drop_cnt_q;
        if (capture) begin
            out_data_d                 = '0;
            out_data_d[NOUT*OW-1:0]    = k_out_tdata;
            out_valid_d                = 1'b1;
        end else if (lii_out_tready) begin
            out_valid_d = 1'b0;
        end
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Output register and drop counter state.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign lii_out_tdata  = out_data_q;
    assign lii_out_tvalid = out_valid_q;
    assign lii_out_src    = MY_ID;
    assign lii_out_dst    = DST_ID;
    assign drop_cnt       = drop_cnt_q;
    assign ce             = !(out_valid_q & !lii_out_tready);

endmodule

// File: tb/tb_lii_stream_adapter.sv
// Directed bench for lii_stream_adapter with NIN=3, IW=64, DEPTH=4, NOUT=2, OW=8.
module tb_lii_stream_adapter;

    localparam int NIN  = 3;
    localparam int NOUT = 2;
    localparam int IW   = 64;
    localparam int OW   = 8;
    localparam int PW   = 256;

    logic                 aclk = 1'b0;
    logic                 arstn;
    logic [PW-1:0]        lii_in_tdata;
    logic                 lii_in_tvalid;
    logic                 lii_in_tready;
    logic [7:0]           lii_in_src;
    logic [7:0]           lii_in_dst;
    logic [PW-1:0]        lii_out_tdata;
    logic                 lii_out_tvalid;
    logic                 lii_out_tready;
    logic [7:0]           lii_out_src;
    logic [7:0]           lii_out_dst;
    logic [NIN*IW-1:0]    k_in_tdata;
    logic [NIN-1:0]       k_in_tvalid;
    logic [NIN-1:0]       k_in_tready;
    logic [NOUT*OW-1:0]   k_out_tdata;
    logic [NOUT-1:0]      k_out_tvalid;
    logic [NOUT-1:0]      k_out_tready;
    logic                 ce;
    logic [15:0]          drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    lii_stream_adapter #(
        .NIN(NIN), .NOUT(NOUT), .IW(IW), .OW(OW), .PW(PW), .DEPTH(4),
        .MY_ID(8'h01), .DST_ID(8'h02)
    ) dut (
        .aclk(aclk), .arstn(arstn),
        .lii_in_tdata(lii_in_tdata), .lii_in_tvalid(lii_in_tvalid),
        .lii_in_tready(lii_in_tready), .lii_in_src(lii_in_src),
        .lii_in_dst(lii_in_dst),
        .lii_out_tdata(lii_out_tdata), .lii_out_tvalid(lii_out_tvalid),
        .lii_out_tready(lii_out_tready), .lii_out_src(lii_out_src),
        .lii_out_dst(lii_out_dst),
        .k_in_tdata(k_in_tdata), .k_in_tvalid(k_in_tvalid),
        .k_in_tready(k_in_tready),
        .k_out_tdata(k_out_tdata), .k_out_tvalid(k_out_tvalid),
        .k_out_tready(k_out_tready),
        .ce(ce), .drop_cnt(drop_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lane_val(input int b, input int i);
        return {32'(b), 32'(i)};
    endfunction

    task automatic drive_beat(input int b, input logic [7:0] dst);
        lii_in_tdata = '0;
        for (int i = 0; i < NIN; i++) lii_in_tdata[i*IW +: IW] = lane_val(b, i);
        lii_in_dst    = dst;
        lii_in_tvalid = 1'b1;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_heads(input string tag, input int b);
        for (int i = 0; i < NIN; i++)
            check(tag, 256'(k_in_tdata[i*IW +: IW]), 256'(lane_val(b, i)));
    endtask

    int n_acc;
    int got;

    initial begin
        arstn          = 1'b0;
        lii_in_tdata   = '0;
        lii_in_tvalid  = 1'b0;
        lii_in_src     = 8'h55;
        lii_in_dst     = 8'h01;
        lii_out_tready = 1'b1;
        k_in_tready    = '0;
        k_out_tdata    = '0;
        k_out_tvalid   = '0;

        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        check("rst_k_in_tvalid", 256'(k_in_tvalid), 256'(0));
        check("rst_out_tvalid", 256'(lii_out_tvalid), 256'(0));
        check("rst_out_tdata", lii_out_tdata, 256'(0));
        check("rst_drop_cnt", 256'(drop_cnt), 256'(0));
        check("rst_in_tready", 256'(lii_in_tready), 256'(1));
        check("rst_ce", 256'(ce), 256'(1));
        check("rst_k_out_tready", 256'(k_out_tready), 256'(0));
        @(negedge aclk);
        arstn = 1'b1;
        tick();

        // 1: six beats streamed through with the kernel always ready
        k_in_tready = 3'b111;
        for (int b = 0; b < 6; b++) begin
            drive_beat(b, 8'h01);
            #1;
            check("t1_in_tready", 256'(lii_in_tready), 256'(1));
            @(posedge aclk);
            #1;
            @(negedge aclk);
            check("t1_k_in_tvalid", 256'(k_in_tvalid), 256'(3'b111));
            check_heads("t1_head", b);
        end
        lii_in_tvalid = 1'b0;
        tick();
        check("t1_drained", 256'(k_in_tvalid), 256'(0));

        // 2: kernel stalled, fill to DEPTH, then pop one lane at a time
        k_in_tready = 3'b000;
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            drive_beat(10 + n_acc, 8'h01);
            #1;
            if (lii_in_tready) n_acc++;
            tick();
        end
        lii_in_tvalid = 1'b0;
        check("t2_accepted", 256'(n_acc), 256'(4));
        check("t2_full_tready", 256'(lii_in_tready), 256'(0));
        check_heads("t2_head_full", 10);
        k_in_tready = 3'b001;
        tick();
        k_in_tready = 3'b000;
        #1;
        check("t2_pop0_tready", 256'(lii_in_tready), 256'(0));
        check("t2_pop0_lane0", 256'(k_in_tdata[0 +: IW]), 256'(lane_val(11, 0)));
        check("t2_pop0_lane1", 256'(k_in_tdata[IW +: IW]), 256'(lane_val(10, 1)));
        k_in_tready = 3'b010;
        tick();
        k_in_tready = 3'b000;
        #1;
        check("t2_pop1_tready", 256'(lii_in_tready), 256'(0));
        k_in_tready = 3'b100;
        tick();
        k_in_tready = 3'b000;
        #1;
        check("t2_pop2_tready", 256'(lii_in_tready), 256'(1));
        check_heads("t2_head_after", 11);
        k_in_tready = 3'b111;
        repeat (3) tick();
        check("t2_drained", 256'(k_in_tvalid), 256'(0));

        // 3: destination filter, alternating dst
        got = 0;
        for (int b = 0; b < 10; b++) begin
            drive_beat(20 + b, (b % 2 == 0) ? 8'h01 : 8'h07);
            tick();
            if (k_in_tvalid == 3'b111) begin
                check_heads("t3_head", 20 + 2 * got);
                got++;
            end
        end
        lii_in_tvalid = 1'b0;
        tick();
        check("t3_delivered", 256'(got), 256'(5));
        check("t3_drop_cnt", 256'(drop_cnt), 256'(5));
        check("t3_k_in_idle", 256'(k_in_tvalid), 256'(0));

        // 3b: drive the drop counter to saturation
        lii_in_dst    = 8'h07;
        lii_in_tvalid = 1'b1;
        repeat (65528) @(posedge aclk);
        #1;
        lii_in_tvalid = 1'b0;
        check("t3_drop_near_sat", 256'(drop_cnt), 256'(16'hFFFD));
        lii_in_tvalid = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check("t3_drop_sat", 256'(drop_cnt), 256'(16'hFFFF));
        tick();
        lii_in_tvalid = 1'b0;
        check("t3_drop_hold", 256'(drop_cnt), 256'(16'hFFFF));
        check("t3_k_in_none", 256'(k_in_tvalid), 256'(0));

        // 4: output packing waits for every lane
        lii_out_tready = 1'b1;
        k_out_tdata    = 16'h00A5;
        k_out_tvalid   = 2'b01;
        #1;
        check("t4_partial_ready", 256'(k_out_tready), 256'(0));
        tick();
        check("t4_partial_nocap", 256'(lii_out_tvalid), 256'(0));
        k_out_tdata  = 16'h3CA5;
        k_out_tvalid = 2'b11;
        #1;
        check("t4_full_ready", 256'(k_out_tready), 256'(2'b11));
        tick();
        k_out_tvalid   = 2'b00;
        lii_out_tready = 1'b0;
        #1;
        check("t4_out_tvalid", 256'(lii_out_tvalid), 256'(1));
        check("t4_out_tdata", lii_out_tdata, 256'(16'h3CA5));
        check("t4_out_src", 256'(lii_out_src), 256'(8'h01));
        check("t4_out_dst", 256'(lii_out_dst), 256'(8'h02));

        // 5: backpressure freezes the kernel and holds the beat
        check("t5_ce_blocked", 256'(ce), 256'(0));
        k_out_tdata  = 16'h7711;
        k_out_tvalid = 2'b11;
        #1;
        check("t5_k_out_blocked", 256'(k_out_tready), 256'(0));
        repeat (2) tick();
        check("t5_data_stable", lii_out_tdata, 256'(16'h3CA5));
        check("t5_valid_stable", 256'(lii_out_tvalid), 256'(1));
        lii_out_tready = 1'b1;
        #1;
        check("t5_ce_release", 256'(ce), 256'(1));
        check("t5_k_out_release", 256'(k_out_tready), 256'(2'b11));
        tick();
        k_out_tvalid = 2'b00;
        #1;
        check("t5_next_valid", 256'(lii_out_tvalid), 256'(1));
        check("t5_next_data", lii_out_tdata, 256'(16'h7711));
        tick();
        check("t5_cleared", 256'(lii_out_tvalid), 256'(0));

        // 6: reset mid-transfer
        k_in_tready = 3'b000;
        drive_beat(40, 8'h01);
        tick();
        drive_beat(41, 8'h01);
        tick();
        lii_in_tvalid  = 1'b0;
        lii_out_tready = 1'b0;
        k_out_tdata    = 16'h5A66;
        k_out_tvalid   = 2'b11;
        tick();
        k_out_tvalid = 2'b00;
        #1;
        check("t6_pre_k_in", 256'(k_in_tvalid), 256'(3'b111));
        check("t6_pre_out", 256'(lii_out_tvalid), 256'(1));
        #1;
        arstn = 1'b0;
        #1;
        check("t6_k_in_tvalid", 256'(k_in_tvalid), 256'(0));
        check("t6_out_tvalid", 256'(lii_out_tvalid), 256'(0));
        check("t6_out_tdata", lii_out_tdata, 256'(0));
        check("t6_drop_cnt", 256'(drop_cnt), 256'(0));
        check("t6_in_tready", 256'(lii_in_tready), 256'(1));
        @(negedge aclk);
        arstn          = 1'b1;
        lii_out_tready = 1'b1;
        k_in_tready    = 3'b111;
        drive_beat(50, 8'h01);
        tick();
        lii_in_tvalid = 1'b0;
        check("t6_post_k_in", 256'(k_in_tvalid), 256'(3'b111));
        check_heads("t6_post_head", 50);
        tick();
        check("t6_post_drained", 256'(k_in_tvalid), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
